// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier control slice.
//   mult_state_t         : control FSM state encoding
//   MULT_N_BITS_DEFAULT  : default operand width / iteration count
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR_XA = 3'd1,
        ADD    = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } mult_state_t;

    localparam int MULT_N_BITS_DEFAULT = 8;

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier FSM.
//   Clk      in   system clock
//   Reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear to 0 (has priority over en)
//   en       in   increment by one
//   tc       out  terminal count: counter sits at N_BITS-1
module mult_iter_cnt #(
    parameter int N_BITS = 8,
    localparam int CW    = $clog2(N_BITS)
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(N_BITS - 1));

endmodule

// File: rtl/mult_control_unit.sv
// Control FSM for the signed shift-add multiplier datapath.
// One multiply per Run request: clear X:A, then N_BITS add/sub + shift
// iterations, then hold in DONE until Run is released.
//   Clk           in   system clock
//   Reset_n       in   asynchronous active-low reset
//   Run           in   start request (level)
//   ClearA_LoadB  in   idle-only request: clear X:A, load B
//   M             in   current multiplier LSB B[0]
//   Clr_Ld        out  clear X:A and load B
//   Clear_XA      out  clear X and A at start of a multiply
//   Add           out  A <= A + S
//   Sub           out  A <= A - S (last iteration only)
//   Shift         out  arithmetic right shift of X:A:B
//   Busy          out  multiply in progress
//   Done          out  result held
//
// state  | meaning
// IDLE   | waiting; Clr_Ld follows ClearA_LoadB, Run starts a multiply
// CLR_XA | clear X:A, reset iteration count
// ADD    | add (or subtract on last iteration) S when M=1
// SHIFT  | shift X:A:B right; loop to ADD or finish
// DONE   | product valid; wait for Run to drop
module mult_control_unit
    import mult_pkg::*;
#(
    parameter int N_BITS = MULT_N_BITS_DEFAULT
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clear_XA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    mult_state_t state;
    mult_state_t next_state;
    logic        last_iter;

    mult_iter_cnt #(
        .N_BITS (N_BITS)
    ) u_iter_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (state == CLR_XA),
        .en      ((state == SHIFT) && !last_iter),
        .tc      (last_iter)
    );

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (ClearA_LoadB) next_state = IDLE;
                else if (Run)     next_state = CLR_XA;
                else              next_state = IDLE;
            end
            CLR_XA:  next_state = ADD;
            ADD:     next_state = SHIFT;
            SHIFT:   next_state = last_iter ? DONE : ADD;
            DONE:    next_state = Run ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with
    // the state they belong to; Add/Sub/Clr_Ld depend on live inputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Clear_XA <= 1'b0;
            Shift    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= next_state;
            Clear_XA <= (next_state == CLR_XA);
            Shift    <= (next_state == SHIFT);
            Busy     <= (next_state == CLR_XA) || (next_state == ADD) ||
                        (next_state == SHIFT);
            Done     <= (next_state == DONE);
        end
    end

    // Clr_Ld is gated by reset so the datapath cannot load while held in reset.
    assign Clr_Ld = Reset_n && (state == IDLE) && ClearA_LoadB;
    assign Add    = (state == ADD) && M && !last_iter;
    assign Sub    = (state == ADD) && M && last_iter;

endmodule
